// File: rtl/commit_checker_pkg.sv
// commit_chk_pkg: definitions shared by the commit checker files.
//   state_t        - checker state (RUN, HALT, DONE)
//   commit_entry_t - one writeback commit (destination register + data) in
//                    the default MIPS configuration (5-bit index, 32-bit data)
//   clog2          - ceiling log2, used to size the FIFO pointers
package commit_chk_pkg;

  localparam int DEF_ADDR_W = 5;
  localparam int DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    HALT = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } commit_entry_t;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/commit_checker_if.sv
// commit_checker_if: the two commit streams that feed the checker.
//   dut_valid/dut_addr/dut_data - commits tapped from the core's writeback
//   ref_valid/ref_addr/ref_data - expected commits from the reference model
//   ref_ready                   - checker can take a reference commit
// master: the environment driving both streams; slave: the checker.
interface commit_checker_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);

  logic              dut_valid;
  logic [ADDR_W-1:0] dut_addr;
  logic [DATA_W-1:0] dut_data;
  logic              ref_valid;
  logic [ADDR_W-1:0] ref_addr;
  logic [DATA_W-1:0] ref_data;
  logic              ref_ready;

  modport master (
    output dut_valid, dut_addr, dut_data,
    output ref_valid, ref_addr, ref_data,
    input  ref_ready
  );

  modport slave (
    input  dut_valid, dut_addr, dut_data,
    input  ref_valid, ref_addr, ref_data,
    output ref_ready
  );

endinterface

// File: rtl/commit_checker_fifo.sv
// commit_fifo: synchronous FIFO holding buffered commits.
//   clk, rst   - clock, asynchronous active-low reset
//   push       - write push_data (ignored when full unless popping too)
//   pop        - drop the head entry (ignored when empty)
//   head       - current head entry, valid whenever !empty
//   full/empty - occupancy flags
//   count      - number of stored entries
// Pointers carry one extra bit so full and empty are told apart by the MSB.
module commit_fifo
  import commit_chk_pkg::*;
#(
  parameter int WIDTH = 37,
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [clog2(DEPTH):0]  count
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count = wr_ptr - rd_ptr;
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/commit_checker.sv
// commit_checker: lockstep compare of the core's writeback commits against a
// reference model's expected commits.
//   clk, rst       - clock, asynchronous active-low reset
//   bus            - both commit streams and ref_ready (slave side)
//   mismatch       - one-cycle pulse per failed compare
//   err_cnt        - saturating mismatch count
//   match_cnt      - saturating match count
//   first_err_*    - DUT address, expected data and DUT data of first mismatch
//   overflow       - sticky, a DUT commit was dropped on a full FIFO
//   halted / done  - state is HALT / DONE
module commit_checker
  import commit_chk_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int DEPTH       = 8,
  parameter int CNT_W       = 32,
  parameter int TARGET      = 20000,
  parameter int STOP_ON_ERR = 1
) (
  input  logic              clk,
  input  logic              rst,
  commit_checker_if.slave   bus,
  output logic              mismatch,
  output logic [CNT_W-1:0]  err_cnt,
  output logic [CNT_W-1:0]  match_cnt,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_exp,
  output logic [DATA_W-1:0] first_err_got,
  output logic              overflow,
  output logic              halted,
  output logic              done
);

  localparam int EW = ADDR_W + DATA_W;
  localparam int PW = clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] TARGET_C = CNT_W'(TARGET);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } entry_t;

  entry_t            dut_in, ref_in, dut_head, ref_head;
  logic              dut_push, ref_push, pop;
  logic              dut_full, dut_empty, ref_full, ref_empty;
  logic [PW-1:0]     dut_count, ref_count;
  logic              unused_counts;
  logic              ready_en;
  state_t            state, next_state;

  logic              cmp_valid, cmp_match;
  logic [ADDR_W-1:0] cmp_addr;
  logic [DATA_W-1:0] cmp_exp, cmp_got;
  logic [CNT_W-1:0]  match_inc, err_inc;
  logic              hit;

  assign unused_counts = ^{dut_count, ref_count};

  // Register 0 writes are never compared, so they are filtered before the FIFOs.
  assign dut_in   = '{addr: bus.dut_addr, data: bus.dut_data};
  assign ref_in   = '{addr: bus.ref_addr, data: bus.ref_data};
  assign dut_push = bus.dut_valid && (bus.dut_addr != '0);
  assign ref_push = bus.ref_valid && bus.ref_ready && (bus.ref_addr != '0);

  // ready_en keeps ref_ready low during reset and for the first cycle after.
  assign bus.ref_ready = ready_en && (!ref_full || pop);

  // No new pop once the pending result is about to leave RUN, so a halt
  // really stops on the first mismatch.
  assign pop = (state == RUN) && (next_state == RUN) && !dut_empty && !ref_empty;

  commit_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_dut_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (dut_push),
    .push_data (dut_in),
    .pop       (pop),
    .head      (dut_head),
    .full      (dut_full),
    .empty     (dut_empty),
    .count     (dut_count)
  );

  commit_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_ref_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (ref_push),
    .push_data (ref_in),
    .pop       (pop),
    .head      (ref_head),
    .full      (ref_full),
    .empty     (ref_empty),
    .count     (ref_count)
  );

  assign match_inc = (match_cnt == '1) ? match_cnt : match_cnt + CNT_W'(1);
  assign err_inc   = (err_cnt == '1) ? err_cnt : err_cnt + CNT_W'(1);
  assign mismatch  = cmp_valid && !cmp_match;
  assign hit       = cmp_valid && cmp_match && (match_inc == TARGET_C);
  assign halted    = (state == HALT);
  assign done      = (state == DONE);

  always_comb begin
    next_state = state;
    case (state)
      RUN: begin
        if (mismatch && (STOP_ON_ERR != 0)) next_state = HALT;
        else if (hit)                       next_state = DONE;
      end
      default: next_state = state;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RUN;
    else      state <= next_state;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ready_en  <= 1'b0;
      overflow  <= 1'b0;
      cmp_valid <= 1'b0;
      cmp_match <= 1'b0;
      cmp_addr  <= '0;
      cmp_exp   <= '0;
      cmp_got   <= '0;
    end else begin
      ready_en  <= 1'b1;
      if (dut_push && dut_full && !pop) overflow <= 1'b1;
      cmp_valid <= pop;
      if (pop) begin
        cmp_match <= (dut_head.addr == ref_head.addr) &&
                     (dut_head.data == ref_head.data);
        cmp_addr  <= dut_head.addr;
        cmp_exp   <= ref_head.data;
        cmp_got   <= dut_head.data;
      end
    end
  end

  // Counters and first-error capture follow the registered compare result.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      match_cnt      <= '0;
      err_cnt        <= '0;
      first_err_addr <= '0;
      first_err_exp  <= '0;
      first_err_got  <= '0;
    end else if (cmp_valid) begin
      if (cmp_match) begin
        match_cnt <= match_inc;
      end else begin
        err_cnt <= err_inc;
        if (err_cnt == '0) begin
          first_err_addr <= cmp_addr;
          first_err_exp  <= cmp_exp;
          first_err_got  <= cmp_got;
        end
      end
    end
  end

endmodule

// File: doc/commit_checker.md
# commit_checker

Synthesizable lockstep commit checker for the MIPS core's verification environment, generalising the bench-level register-file compare into a parametrised block. It sits beside `Processor`, taps the writeback commit stream (`WB_inst_en` plus destination and data), and consumes the expected commit stream from a reference model. It buffers both streams in independent FIFOs, compares them in order, counts matches and errors, and halts or signals completion. The block works in simulation and on FPGA.

## Interface
- `DATA_W`, 32: commit data width
- `ADDR_W`, 5: register index width
- `DEPTH`, 8: entries per FIFO, power of 2, at least 2
- `CNT_W`, 32: width of match and error counters
- `TARGET`, 20000: match count that asserts `done`
- `STOP_ON_ERR`, 1: 1 = halt on first mismatch; 0 = keep comparing
- `clk` in 1: clock, rising edge
- `rst` in 1: asynchronous, active-low reset
- `dut_valid` in 1: DUT commit strobe (`WB_inst_en`)
- `dut_addr` in `ADDR_W`: DUT destination register
- `dut_data` in `DATA_W`: DUT write data
- `ref_valid` in 1: reference commit valid
- `ref_addr` in `ADDR_W`: reference destination register
- `ref_data` in `DATA_W`: reference write data
- `ref_ready` out 1: reference FIFO can accept
- `mismatch` out 1: one-cycle pulse per failed compare
- `err_cnt` out `CNT_W`: saturating error count
- `match_cnt` out `CNT_W`: saturating match count
- `first_err_addr` out `ADDR_W`: DUT address of the first mismatch
- `first_err_exp` out `DATA_W`: expected data of the first mismatch
- `first_err_got` out `DATA_W`: DUT data of the first mismatch
- `overflow` out 1: sticky; a DUT commit was lost because its FIFO was full
- `halted` out 1: state is HALT
- `done` out 1: state is DONE

## Operation
- **Push filter:** commits with addr 0 are discarded on both sides. Register 0 is never compared.
- **DUT FIFO:**
  - Pushes on `dut_valid` with addr ≠ 0. There is no backpressure.
  - A push when full and not popping is dropped and sets `overflow`.
- **Reference FIFO:**
  - Pushes on `ref_valid && ref_ready`.
  - `ref_ready = !full || pop`.
- **Compare:**
  - In RUN, when both FIFOs are non-empty, pop both heads in the same cycle.
  - Compare addr and data.
  - Register the result for one cycle, then update the counters and `mismatch`.
- **On mismatch:**
  - `err_cnt` increments.
  - If `err_cnt` was 0, capture the three `first_err_*` fields.
  - If `STOP_ON_ERR`, go to HALT.
- **On match:** `match_cnt` increments. When it reaches `TARGET`, go to DONE.
- **State machine:**
  - RUN → HALT: mismatch with `STOP_ON_ERR` = 1.
  - RUN → DONE: `match_cnt` = `TARGET`.
  - HALT and DONE are absorbing until reset.
  - If one compare both mismatches and hits `TARGET`, HALT wins.
- **In HALT or DONE:**
  - No pops.
  - FIFOs keep accepting until full; `ref_ready` then drops.
  - DUT pushes into a full FIFO still set `overflow`.
- **Counters:** both saturate at all ones and never wrap.

## Timing
- **Reset values:** all outputs 0, state RUN, FIFOs empty. Consequently `ref_ready` = 1 one cycle after reset release.
- **Latency:**
  - Push to visible head: 1 cycle.
  - Pop to `mismatch`/counter update: 1 cycle.
  - Best case, from simultaneous `dut_valid` and `ref_valid` to `mismatch`: 2 cycles.
- **Throughput:** one compare per cycle.
- **Full FIFO:** a simultaneous push and pop on a full FIFO is legal. Count is unchanged and no overflow is flagged.
- **Empty FIFO:** a push into an empty FIFO cannot pop in the same cycle; there is no bypass.
- **Pointer wrap-around:** pointers are `log2(DEPTH)+1` bits. Full/empty is decided by the MSB difference.
- **Async reset:** assertion mid-operation clears everything immediately, including in-flight compare results. Sticky flags also clear.

## Structure
- **Shared package `commit_chk_pkg`:**
  - State enum: RUN, HALT, DONE.
  - Commit entry struct: addr, data.
  - Helper function `clog2`.
- **Sub-module `commit_fifo`:** parametrised on `ADDR_W+DATA_W` and `DEPTH`. Provides push/pop/full/empty/count. Instantiated twice.
- **Top level:** filter, compare register, counters, first-error capture, FSM.

## Test plan
- **Lockstep clean run:** `TARGET`=4. Four identical commits on both sides (r1=0x1, r2=0x2, r3=0x3, r4=0x4) → `match_cnt`=4, `done`=1, `err_cnt`=0.
- **First-error capture:** DUT r5=0xDEADBEEF, ref r5=0xDEADBEEE, `STOP_ON_ERR`=1 → `mismatch` pulses once, 2 cycles after the inputs. Also:
  - `halted`=1, `first_err_addr`=5.
  - `first_err_exp`=0xDEADBEEE, `first_err_got`=0xDEADBEEF.
  - A later ref push fills the FIFO, then `ref_ready`=0.
- **Continue mode:** `STOP_ON_ERR`=0, 3 mismatches interleaved with 2 matches → `err_cnt`=3, `match_cnt`=2. First-error fields hold the first mismatch only.
- **Skew and overflow:**
  - `DEPTH`=4, 5 DUT commits with no ref commits → `overflow`=1.
  - Then feed 4 matching ref commits → `match_cnt`=4, `err_cnt`=0.
- **Register-0 filter:** DUT r0=0x1234, ref r0=0x5678, then matching r7 on both → `match_cnt`=1, `err_cnt`=0.
- **Reset mid-compare:** drop `rst` on the cycle after a mismatching pop → `mismatch` never asserts, all counters 0, state RUN.
